// File: rtl/serial_paralelo_rx_pkg.sv
// Shared constants and state encoding for the serial-to-parallel lane receiver.
package serial_paralelo_rx_pkg;

  localparam logic [7:0] COMMA = 8'hBC;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ALIGN = 2'd1,
    SYNC  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Lane bus: serial bit in, aligned byte stream out toward the unstriping stage.
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;

  // master feeds the serial bit and consumes bytes; slave is the receiver
  modport master (output data_in, input data_out, input valid_out, input byte_stb, input active);
  modport slave  (input data_in, output data_out, output valid_out, output byte_stb, output active);
endinterface

// File: rtl/serial_paralelo_rx_comma_detect.sv
// Combinational match of the current 8-bit window against the comma symbol.
module serial_paralelo_rx_comma_detect
  import serial_paralelo_rx_pkg::*;
(
  input  logic [7:0] word_i,
  output logic       is_comma_o
);
  assign is_comma_o = (word_i == COMMA);
endmodule

// File: rtl/serial_paralelo_rx.sv
// Single-lane receiver: hunts for comma alignment, then emits one byte slot every 8 bits.
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter int unsigned BC_NEEDED = 4
) (
  input  logic                 clk_32f,
  input  logic                 reset_L,
  serial_paralelo_rx_if.slave  rx
);

  localparam logic [3:0] BC_TGT    = 4'(BC_NEEDED);
  localparam bit         ONE_COMMA = (BC_NEEDED == 1);

  rx_state_t  state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] bc_cnt_q;
  logic [7:0] data_out_q;
  logic       valid_out_q;
  logic       byte_stb_q;
  logic       active_q;

  logic [7:0] word_d;
  logic       is_comma;

  assign word_d = {shift_q[6:0], rx.data_in};

  serial_paralelo_rx_comma_detect u_comma (
    .word_i     (word_d),
    .is_comma_o (is_comma)
  );

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= HUNT;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      bc_cnt_q    <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      byte_stb_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      shift_q <= word_d;
      case (state_q)
        HUNT: begin
          byte_stb_q <= 1'b0;
          // Any bit offset may start alignment; the comma's last bit sets the phase
          if (is_comma) begin
            bit_cnt_q <= '0;
            bc_cnt_q  <= 4'd1;
            if (ONE_COMMA) begin
              state_q  <= SYNC;
              active_q <= 1'b1;
            end else begin
              state_q <= ALIGN;
            end
          end
        end
        ALIGN: begin
          byte_stb_q <= 1'b0;
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (is_comma) begin
              if (bc_cnt_q + 4'd1 == BC_TGT) begin
                bc_cnt_q <= BC_TGT;
                state_q  <= SYNC;
                active_q <= 1'b1;
              end else begin
                bc_cnt_q <= bc_cnt_q + 4'd1;
              end
            end else begin
              bc_cnt_q <= '0;
              state_q  <= HUNT;
            end
          end
        end
        SYNC: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          // Lock is sticky; a comma in a slot marks it idle and keeps the last data
          if (bit_cnt_q == 3'd7) begin
            byte_stb_q <= 1'b1;
            if (is_comma) begin
              valid_out_q <= 1'b0;
            end else begin
              data_out_q  <= word_d;
              valid_out_q <= 1'b1;
            end
          end else begin
            byte_stb_q <= 1'b0;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign rx.data_out  = data_out_q;
  assign rx.valid_out = valid_out_q;
  assign rx.byte_stb  = byte_stb_q;
  assign rx.active    = active_q;

endmodule
